// File: rtl/pc_redirect_unit.sv
// Fetch-side program counter with taken-branch redirect and pipeline squash.
// Tracks misaligned targets and counts redirects (saturating).
module pc_redirect_unit #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              PC_STEP      = 4,
    parameter int              FLUSH_CYCLES = 2,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  pc_out,
    output logic             fetch_valid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_count
);

    localparam int FW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FW-1:0]    FC_V   = FW'(FLUSH_CYCLES);
    localparam logic [FW-1:0]    ONE_F  = FW'(1);
    localparam logic [XLEN-1:0]  STEP_V = XLEN'(PC_STEP);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]  pc_d;
    logic             mis_d;
    logic [CNT_W-1:0] tc_d;
    logic             fv_d;
    logic             flush_d;
    logic             advance;

    assign advance = fetch_ready & ~stall;

    // Next-state, next-PC and bookkeeping for redirects and squashes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_out;
        mis_d   = misalign_err;
        tc_d    = taken_count;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (branch_taken) begin
                    pc_d    = {branch_target[XLEN-1:2], 2'b00};
                    mis_d   = misalign_err | (|branch_target[1:0]);
                    if (taken_count != '1) begin
                        tc_d = taken_count + ONE_C;
                    end
                    cnt_d   = FC_V;
                    state_d = FLUSH;
                end else if (advance) begin
                    pc_d = pc_out + STEP_V;
                end
            end
            FLUSH: begin
                if (advance) begin
                    pc_d = pc_out + STEP_V;
                end
                cnt_d = cnt_q - ONE_F;
                if (cnt_q <= ONE_F) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = BOOT;
            end
        endcase
        fv_d    = (state_d != BOOT);
        flush_d = (cnt_d != '0);
    end

    // State and registered outputs; reset abandons any flush in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= BOOT;
            cnt_q        <= '0;
            pc_out       <= RESET_PC;
            fetch_valid  <= 1'b0;
            flush_ifid   <= 1'b0;
            flush_idex   <= 1'b0;
            misalign_err <= 1'b0;
            taken_count  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_out       <= pc_d;
            fetch_valid  <= fv_d;
            flush_ifid   <= flush_d;
            flush_idex   <= flush_d;
            misalign_err <= mis_d;
            taken_count  <= tc_d;
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: directed scenarios then random
// traffic, checked against a cycle-level behavioural model.
module tb_pc_redirect_unit;

    localparam int          XLEN = 64;
    localparam int          STEP = 4;
    localparam int          FC   = 2;
    localparam int          CW   = 4;
    localparam logic [63:0] RPC  = 64'h0;
    localparam int          CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            stall = 1'b0;
    logic            branch_taken = 1'b0;
    logic [63:0]     branch_target = '0;
    logic            fetch_ready = 1'b0;
    logic [63:0]     pc_out;
    logic            fetch_valid;
    logic            flush_ifid;
    logic            flush_idex;
    logic            misalign_err;
    logic [CW-1:0]   taken_count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0]   pc;
        logic          fv;
        logic          fi;
        logic          fe;
        logic          mis;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];

    // behavioural model
    bit          m_boot;
    int          m_left;
    logic [63:0] m_pc;
    bit          m_mis;
    int          m_cnt;

    pc_redirect_unit #(
        .XLEN(XLEN), .RESET_PC(RPC), .PC_STEP(STEP),
        .FLUSH_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .fetch_ready(fetch_ready), .pc_out(pc_out),
        .fetch_valid(fetch_valid), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .misalign_err(misalign_err),
        .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        m_boot = 1;
        m_left = 0;
        m_pc   = RPC;
        m_mis  = 0;
        m_cnt  = 0;
    endfunction

    // one rising edge with the inputs currently applied
    function automatic void m_step();
        if (reset) begin
            m_reset();
            return;
        end
        if (m_boot) begin
            m_boot = 0;
            return;
        end
        if (m_left == 0 && branch_taken) begin
            m_pc = branch_target & ~64'd3;
            if (branch_target[1:0] != 2'b00) m_mis = 1;
            if (m_cnt < CMAX) m_cnt++;
            m_left = FC;
        end else begin
            if (!stall && fetch_ready) m_pc = m_pc + 64'(STEP);
            if (m_left > 0) m_left--;
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.pc  = m_pc;
        e.fv  = !m_boot;
        e.fi  = (m_left > 0);
        e.fe  = (m_left > 0);
        e.mis = m_mis;
        e.cnt = CW'(m_cnt);
        q.push_back(e);
    endfunction

    task automatic cyc(input bit r, input bit s, input bit t,
                       input logic [63:0] tg, input bit rd);
        @(posedge clk);
        #1;
        m_step();
        reset         = r;
        stall         = s;
        branch_taken  = t;
        branch_target = tg;
        fetch_ready   = rd;
        if (r) m_reset();
        push_exp();
    endtask

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // monitor: compare every presented cycle against the scoreboard
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_out", pc_out, e.pc);
            chk("fetch_valid", 64'(fetch_valid), 64'(e.fv));
            chk("flush_ifid", 64'(flush_ifid), 64'(e.fi));
            chk("flush_idex", 64'(flush_idex), 64'(e.fe));
            chk("misalign_err", 64'(misalign_err), 64'(e.mis));
            chk("taken_count", 64'(taken_count), 64'(e.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        // reset, release, sequential fetch
        repeat (3) cyc(1, 0, 0, 64'h0, 1);
        repeat (5) cyc(0, 0, 0, 64'h0, 1);
        // redirect to 0x100
        cyc(0, 0, 1, 64'h100, 1);
        repeat (5) cyc(0, 0, 0, 64'h0, 1);
        // redirect together with stall, then wrong-path taken
        cyc(0, 1, 1, 64'h400, 1);
        cyc(0, 0, 1, 64'h800, 1);
        cyc(0, 0, 1, 64'h900, 1);
        repeat (3) cyc(0, 0, 0, 64'h0, 1);
        // misaligned target, sticky error
        cyc(0, 0, 1, 64'h202, 1);
        repeat (6) cyc(0, 0, 0, 64'h0, 1);
        // wrap at top of address space, then holds
        cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        repeat (3) cyc(0, 0, 0, 64'h0, 1);
        repeat (3) cyc(0, 1, 0, 64'h0, 1);
        repeat (3) cyc(0, 0, 0, 64'h0, 0);
        // reset during first flush cycle
        cyc(0, 0, 1, 64'h3000, 1);
        cyc(1, 0, 0, 64'h0, 1);
        cyc(1, 0, 1, 64'h500, 1);
        cyc(0, 0, 1, 64'h500, 1);
        repeat (3) cyc(0, 0, 0, 64'h0, 1);
        // counter saturation
        for (int i = 0; i < CMAX + 4; i++) begin
            cyc(0, 0, 1, 64'(i) << 4, 1);
            repeat (2) cyc(0, 0, 0, 64'h0, 1);
        end
        // random traffic
        for (int i = 0; i < 700; i++) begin
            logic [63:0] tg;
            tg = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) tg = tg & 64'hFFFF;
            cyc($urandom_range(0, 249) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0,
                tg,
                $urandom_range(0, 3) != 0);
        end
        repeat (2) cyc(0, 0, 0, 64'h0, 1);
        @(negedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
